z16_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the Z16 core: fetches 16-bit instructions, holds them in the IR that

---
 rtl/z16_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_z16_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z16_seq_ctrl.sv
// Z16 multi-cycle sequencer: fetch into the IR, then step decode/execute/memory/writeback.
// Owns the PC, the instruction/data memory handshakes and the sticky memory-timeout error.
module z16_seq_ctrl #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int unsigned PC_STEP  = 2,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_rdata,
    output logic [15:0] o_instr,
    input  logic        i_rd_wen,
    input  logic        i_mem_wen,
    output logic        o_rf_we,
    output logic        o_dmem_req,
    input  logic        i_dmem_ack,
    output logic [15:0] o_pc,
    output logic [2:0]  o_state,
    output logic        o_retired,
    output logic        o_busy,
    output logic        o_err
);

    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [15:0]       PC_INC    = 16'(PC_STEP);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                retire;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        retire  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                // An ack arriving on the last counted cycle still wins over the timeout.
                if (i_imem_ack) begin
                    instr_d = i_imem_rdata;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                // A store takes priority; an instruction flagged as both never writes rd.
                if (i_mem_wen) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else if (i_rd_wen) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                if (i_dmem_ack) begin
                    retire = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB:    retire = 1'b1;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            pc_d    = pc_q + PC_INC;
            wait_d  = '0;
            state_d = i_run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            instr_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

    assign o_imem_req  = (state_q == S_FETCH);
    assign o_dmem_req  = (state_q == S_MEM);
    assign o_rf_we     = (state_q == S_WB);
    assign o_err       = (state_q == S_ERR);
    assign o_busy      = (state_q != S_IDLE) && (state_q != S_ERR);
    assign o_retired   = retire;
    assign o_pc        = pc_q;
    assign o_imem_addr = pc_q;
    assign o_instr     = instr_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_z16_seq_ctrl.sv
// Directed bench for z16_seq_ctrl: fixed instruction/ack scripts with hand-computed expectations.
// A tiny decoder stand-in maps specific opcodes to rd/mem write flags.
module tb_z16_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        rd_wen;
    logic        mem_wen;
    logic        rf_we;
    logic        dmem_req;
    logic        dmem_ack;
    logic [15:0] pc;
    logic [2:0]  state;
    logic        retired;
    logic        busy;
    logic        err;

    int unsigned n_checks;
    int unsigned n_fail;

    z16_seq_ctrl #(
        .PC_RESET (16'hFFFE),
        .PC_STEP  (2),
        .TIMEOUT  (16)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_run        (run),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .o_instr      (instr),
        .i_rd_wen     (rd_wen),
        .i_mem_wen    (mem_wen),
        .o_rf_we      (rf_we),
        .o_dmem_req   (dmem_req),
        .i_dmem_ack   (dmem_ack),
        .o_pc         (pc),
        .o_state      (state),
        .o_retired    (retired),
        .o_busy       (busy),
        .o_err        (err)
    );

    // Decoder stand-in: 512A writes rd, 340B stores, 7777 claims both.
    assign rd_wen  = (instr == 16'h512A) || (instr == 16'h7777);
    assign mem_wen = (instr == 16'h340B) || (instr == 16'h7777);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        dmem_ack   = 1'b0;
        tick();
        tick();
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", 32'(pc), 32'h0000FFFE);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);

        // Non-writing instruction, zero-wait fetch; PC wraps FFFE -> 0000.
        rst = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1230;
        #1;
        check("t1_idle", 32'(state), 32'd0);
        tick(); #1;
        check("t1_fetch", 32'(state), 32'd1);
        check("t1_imem_req", 32'(imem_req), 32'd1);
        check("t1_imem_addr", 32'(imem_addr), 32'h0000FFFE);
        check("t1_busy", 32'(busy), 32'd1);
        tick(); imem_ack = 1'b0; #1;
        check("t1_decode", 32'(state), 32'd2);
        check("t1_instr", 32'(instr), 32'h1230);
        check("t1_req_drop", 32'(imem_req), 32'd0);
        tick(); #1;
        check("t1_exec", 32'(state), 32'd3);
        check("t1_retired", 32'(retired), 32'd1);
        check("t1_pc_hold", 32'(pc), 32'h0000FFFE);
        tick(); imem_ack = 1'b1; imem_rdata = 16'h512A; #1;
        check("t1_refetch", 32'(state), 32'd1);
        check("t1_pc_wrap", 32'(pc), 32'h0000);
        check("t1_ret_low", 32'(retired), 32'd0);

        // Register-writing instruction: one rf_we cycle in WB.
        tick(); imem_ack = 1'b0; #1;
        check("t2_decode", 32'(state), 32'd2);
        check("t2_instr", 32'(instr), 32'h512A);
        tick(); #1;
        check("t2_exec", 32'(state), 32'd3);
        check("t2_exec_ret", 32'(retired), 32'd0);
        check("t2_exec_we", 32'(rf_we), 32'd0);
        tick(); #1;
        check("t2_wb", 32'(state), 32'd5);
        check("t2_wb_we", 32'(rf_we), 32'd1);
        check("t2_wb_ret", 32'(retired), 32'd1);
        tick(); imem_ack = 1'b1; imem_rdata = 16'h340B; #1;
        check("t2_fetch", 32'(state), 32'd1);
        check("t2_we_low", 32'(rf_we), 32'd0);
        check("t2_pc", 32'(pc), 32'h0002);

        // Store with three wait cycles before the data ack.
        tick(); imem_ack = 1'b0; #1;
        check("t3_decode", 32'(state), 32'd2);
        tick(); #1;
        check("t3_exec", 32'(state), 32'd3);
        check("t3_exec_req", 32'(dmem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); dmem_ack = (i == 3); #1;
            check("t3_mem", 32'(state), 32'd4);
            check("t3_dmem_req", 32'(dmem_req), 32'd1);
            check("t3_retired", 32'(retired), 32'(i == 3));
        end
        tick(); dmem_ack = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h7777; #1;
        check("t3_fetch", 32'(state), 32'd1);
        check("t3_req_low", 32'(dmem_req), 32'd0);
        check("t3_pc", 32'(pc), 32'h0004);

        // Both flags set: store path, no register write.
        tick(); imem_ack = 1'b0; #1;
        check("t3b_decode", 32'(state), 32'd2);
        tick(); #1;
        check("t3b_exec", 32'(state), 32'd3);
        tick(); dmem_ack = 1'b1; #1;
        check("t3b_mem", 32'(state), 32'd4);
        check("t3b_no_we", 32'(rf_we), 32'd0);
        check("t3b_retired", 32'(retired), 32'd1);
        tick(); dmem_ack = 1'b0; #1;
        check("t3b_fetch", 32'(state), 32'd1);
        check("t3b_pc", 32'(pc), 32'h0006);

        // Fetch ack on the last permitted cycle still succeeds.
        for (int i = 1; i <= 15; i++) begin
            tick(); #1;
            check("t4a_wait", 32'(state), 32'd1);
            if (i == 15) begin
                imem_ack = 1'b1; imem_rdata = 16'h1230;
            end
        end
        tick(); imem_ack = 1'b0; #1;
        check("t4a_decode", 32'(state), 32'd2);
        tick(); #1;
        check("t4a_exec_ret", 32'(retired), 32'd1);
        tick(); #1;
        check("t4a_fetch", 32'(state), 32'd1);
        check("t4a_pc", 32'(pc), 32'h0008);

        // No fetch ack for TIMEOUT cycles -> ERR, sticky until reset.
        for (int i = 1; i <= 15; i++) begin
            tick(); #1;
            check("t4_wait", 32'(state), 32'd1);
        end
        tick(); #1;
        check("t4_err_state", 32'(state), 32'd6);
        check("t4_err", 32'(err), 32'd1);
        check("t4_req_low", 32'(imem_req), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_pc", 32'(pc), 32'h0008);
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        tick(); #1;
        check("t4_err_hold", 32'(state), 32'd6);
        check("t4_pc_frozen", 32'(pc), 32'h0008);
        check("t4_ack_ignored", 32'(instr), 32'h1230);
        imem_ack = 1'b0;
        rst = 1'b1;
        tick(); rst = 1'b0; run = 1'b0; #1;
        check("t4_clr_state", 32'(state), 32'd0);
        check("t4_clr_err", 32'(err), 32'd0);
        check("t4_clr_pc", 32'(pc), 32'h0000FFFE);
        check("t4_clr_instr", 32'(instr), 32'h0);

        // Run dropped mid-store: store completes, PC wraps, sequencer idles.
        run = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h340B;
        tick(); #1;
        check("t5_fetch", 32'(state), 32'd1);
        tick(); imem_ack = 1'b0; run = 1'b0; #1;
        check("t5_decode", 32'(state), 32'd2);
        tick(); #1;
        check("t5_exec", 32'(state), 32'd3);
        tick(); #1;
        check("t5_mem", 32'(state), 32'd4);
        check("t5_mem_ret", 32'(retired), 32'd0);
        tick(); dmem_ack = 1'b1; #1;
        check("t5_mem_ack_ret", 32'(retired), 32'd1);
        tick(); dmem_ack = 1'b0; #1;
        check("t5_idle", 32'(state), 32'd0);
        check("t5_pc_wrap", 32'(pc), 32'h0000);
        check("t5_req_low", 32'(dmem_req), 32'd0);
        tick(); #1;
        check("t5_idle_hold", 32'(state), 32'd0);
        check("t5_no_fetch", 32'(imem_req), 32'd0);

        // Reset during a data-memory wait drops the request without retiring.
        run = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h340B;
        tick(); #1;
        check("t6_fetch", 32'(state), 32'd1);
        check("t6_pc", 32'(pc), 32'h0000);
        tick(); imem_ack = 1'b0; #1;
        tick(); #1;
        check("t6_exec", 32'(state), 32'd3);
        tick(); #1;
        check("t6_mem", 32'(state), 32'd4);
        tick(); rst = 1'b1; #1;
        check("t6_mem_wait", 32'(dmem_req), 32'd1);
        check("t6_no_ret_pre", 32'(retired), 32'd0);
        tick(); rst = 1'b0; run = 1'b0; #1;
        check("t6_idle", 32'(state), 32'd0);
        check("t6_req_low", 32'(dmem_req), 32'd0);
        check("t6_pc", 32'(pc), 32'h0000FFFE);
        check("t6_no_ret", 32'(retired), 32'd0);
        check("t6_instr", 32'(instr), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
